// File: rtl/mod_mul_iter.sv
// Iterative modular arithmetic unit: A*B mod q, (A+B) mod q, (A-B) mod q.
// The modulus is a runtime input; multiplication uses interleaved shift-add
// reduction consuming BPC multiplier bits per RUN cycle, MSB first.
module mod_mul_iter #(
  parameter int Q_LEN = 64,
  parameter int BPC   = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_mode_i,
  input  logic [Q_LEN-1:0] in_a_i,
  input  logic [Q_LEN-1:0] in_b_i,
  input  logic [Q_LEN-1:0] in_q_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Q_LEN-1:0] out_c_o,
  output logic             out_err_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int STEPS = Q_LEN / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_RES = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [Q_LEN-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [Q_LEN-1:0]   out_c_q, out_c_d;
  logic               out_err_q, out_err_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  // One reduction step: P = 2P mod q, then optionally P = (P + a) mod q.
  // Intermediates are one bit wider so 2P and P+a (both < 2q) never overflow.
  function automatic logic [Q_LEN-1:0] mod_step(input logic [Q_LEN-1:0] p,
                                                input logic [Q_LEN-1:0] a,
                                                input logic [Q_LEN-1:0] q,
                                                input logic             bit_i);
    logic [Q_LEN:0] t;
    logic [Q_LEN:0] qx;
    qx = {1'b0, q};
    t  = {p, 1'b0};
    if (t >= qx) t = t - qx;
    if (bit_i) t = t + {1'b0, a};
    if (t >= qx) t = t - qx;
    return t[Q_LEN-1:0];
  endfunction

  logic [Q_LEN-1:0] p_chain_s;
  logic [Q_LEN:0]   add_sum_s;
  logic [Q_LEN:0]   add_red_s;
  logic [Q_LEN-1:0] add_res_s;
  logic [Q_LEN-1:0] sub_res_s;

  // Datapath: BPC chained MUL steps plus the single-cycle ADD/SUB results.
  always_comb begin
    p_chain_s = p_q;
    for (int i = 0; i < BPC; i++) begin
      p_chain_s = mod_step(p_chain_s, a_q, m_q, b_q[Q_LEN-1-i]);
    end
    add_sum_s = {1'b0, a_q} + {1'b0, b_q};
    add_red_s = add_sum_s - {1'b0, m_q};
    if (add_sum_s >= {1'b0, m_q}) begin
      add_res_s = add_red_s[Q_LEN-1:0];
    end else begin
      add_res_s = add_sum_s[Q_LEN-1:0];
    end
    if (a_q >= b_q) begin
      sub_res_s = a_q - b_q;
    end else begin
      sub_res_s = a_q - b_q + m_q;
    end
  end

  logic [Q_LEN-1:0] res_s;

  // Control FSM next state, operand latching and output register loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    p_d         = p_q;
    tag_d       = tag_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_err_d   = out_err_q;
    out_tag_d   = out_tag_q;
    res_s       = {Q_LEN{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          mode_d  = in_mode_i;
          a_d     = in_a_i;
          b_d     = in_b_i;
          m_d     = in_q_i;
          tag_d   = in_tag_i;
          p_d     = {Q_LEN{1'b0}};
          err_d   = (in_a_i >= in_q_i) || (in_b_i >= in_q_i) ||
                    (in_q_i < Q_LEN'(2)) || (in_mode_i == MODE_RES);
          if ((in_mode_i == MODE_MUL) && !err_d) begin
            cnt_d = CNT_W'(STEPS - 1);
          end else begin
            cnt_d = {CNT_W{1'b0}};
          end
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (err_q) begin
          res_s = {Q_LEN{1'b0}};
        end else begin
          case (mode_q)
            MODE_MUL: begin
              p_d   = p_chain_s;
              b_d   = b_q << BPC;
              res_s = p_chain_s;
            end
            MODE_ADD: res_s = add_res_s;
            MODE_SUB: res_s = sub_res_s;
            default:  res_s = {Q_LEN{1'b0}};
          endcase
        end
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_c_d     = res_s;
          out_err_d   = err_q;
          out_tag_d   = tag_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mode_q      <= 2'b00;
      a_q         <= {Q_LEN{1'b0}};
      b_q         <= {Q_LEN{1'b0}};
      m_q         <= {Q_LEN{1'b0}};
      p_q         <= {Q_LEN{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_c_q     <= {Q_LEN{1'b0}};
      out_err_q   <= 1'b0;
      out_tag_q   <= {TAG_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      p_q         <= p_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_err_q   <= out_err_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_c_o     = out_c_q;
  assign out_err_o   = out_err_q;
  assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_mod_mul_iter.sv
// Bench for mod_mul_iter: directed scenarios on an 8-bit instance and a
// randomized run on a 64-bit, 4-bits-per-cycle instance against a
// plain-arithmetic reference model.
module tb_mod_mul_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance: Q_LEN=8, BPC=1
  logic       s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_out_err;
  logic [1:0] s_mode = 2'b00;
  logic [7:0] s_a = 8'd0, s_b = 8'd0, s_q = 8'd0, s_tag = 8'd0, s_out_c, s_out_tag;

  mod_mul_iter #(.Q_LEN(8), .BPC(1), .TAG_W(8)) u_small (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_mode_i(s_mode),
    .in_a_i(s_a), .in_b_i(s_b), .in_q_i(s_q), .in_tag_i(s_tag),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_c_o(s_out_c), .out_err_o(s_out_err), .out_tag_o(s_out_tag));

  // Large instance: Q_LEN=64, BPC=4
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_err;
  logic [1:0]  b_mode = 2'b00;
  logic [63:0] b_a = 64'd0, b_b = 64'd0, b_q = 64'd0, b_out_c;
  logic [7:0]  b_tag = 8'd0, b_out_tag;

  mod_mul_iter #(.Q_LEN(64), .BPC(4), .TAG_W(8)) u_big (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_mode_i(b_mode),
    .in_a_i(b_a), .in_b_i(b_b), .in_q_i(b_q), .in_tag_i(b_tag),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_c_o(b_out_c), .out_err_o(b_out_err), .out_tag_o(b_out_tag));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present one request for exactly the accept edge.
  task automatic s_issue(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] tag);
    int n = 0;
    while (!s_in_ready && n < 50) begin tick(); n++; end
    check_eq("s_ready_before_accept", {63'd0, s_in_ready}, 64'd1);
    s_mode = mode; s_a = a; s_b = b; s_q = q; s_tag = tag; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic s_wait(input string tag, input int lat);
    int n = 0;
    while (!s_out_valid && n < 100) begin tick(); n++; end
    check_eq({tag, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic s_result(input string tag, input logic [7:0] c, input logic err, input logic [7:0] t);
    check_eq({tag, "_c"}, 64'(s_out_c), 64'(c));
    check_eq({tag, "_err"}, 64'(s_out_err), 64'(err));
    check_eq({tag, "_tag"}, 64'(s_out_tag), 64'(t));
  endtask

  task automatic s_release(input string tag);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 64'(s_out_valid), 64'd0);
    check_eq({tag, "_ready_back"}, 64'(s_in_ready), 64'd1);
  endtask

  // Reference model: direct modular arithmetic on wide integers.
  function automatic logic [64:0] ref_op(input logic [1:0] mode, input logic [63:0] a,
                                         input logic [63:0] b, input logic [63:0] q);
    logic [127:0] prod;
    logic [64:0]  s;
    if (a >= q || b >= q || q < 64'd2 || mode == 2'b11) return {1'b1, 64'd0};
    case (mode)
      2'b00: begin prod = 128'(a) * 128'(b); prod = prod % 128'(q); return {1'b0, prod[63:0]}; end
      2'b01: begin s = (65'(a) + 65'(b)) % 65'(q); return {1'b0, s[63:0]}; end
      default: begin s = (65'(a) + 65'(q) - 65'(b)) % 65'(q); return {1'b0, s[63:0]}; end
    endcase
  endfunction

  initial begin
    logic [63:0] qb, ra, rb;
    logic [64:0] exp_r;
    logic [7:0]  tag_q[$];
    logic [7:0]  exp_tag;
    int n, lat, stall, r;

    // Reset state
    repeat (3) tick();
    check_eq("rst_in_ready", 64'(s_in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(s_out_valid), 64'd0);
    check_eq("rst_out_c", 64'(s_out_c), 64'd0);
    check_eq("rst_out_err", 64'(s_out_err), 64'd0);
    check_eq("rst_out_tag", 64'(s_out_tag), 64'd0);
    rst_n = 1'b1;
    check_eq("rel_ready_low", 64'(s_in_ready), 64'd0);
    tick();
    check_eq("rel_ready_high", 64'(s_in_ready), 64'd1);

    // 1. MUL 200*100 mod 251
    s_issue(2'b00, 8'd200, 8'd100, 8'd251, 8'h5A);
    check_eq("mul_ready_drop", 64'(s_in_ready), 64'd0);
    s_wait("mul1", 8);
    s_result("mul1", 8'd171, 1'b0, 8'h5A);
    s_release("mul1");

    // 2. ADD / SUB
    s_issue(2'b01, 8'd200, 8'd100, 8'd251, 8'h01); s_wait("add", 1);
    s_result("add", 8'd49, 1'b0, 8'h01); s_release("add");
    s_issue(2'b10, 8'd200, 8'd100, 8'd251, 8'h02); s_wait("sub", 1);
    s_result("sub", 8'd100, 1'b0, 8'h02); s_release("sub");
    s_issue(2'b10, 8'd100, 8'd200, 8'd251, 8'h03); s_wait("sub_wrap", 1);
    s_result("sub_wrap", 8'd151, 1'b0, 8'h03); s_release("sub_wrap");
    s_issue(2'b10, 8'd7, 8'd7, 8'd251, 8'h04); s_wait("sub_zero", 1);
    s_result("sub_zero", 8'd0, 1'b0, 8'h04); s_release("sub_zero");

    // 3. Error cases
    s_issue(2'b00, 8'd251, 8'd1, 8'd251, 8'h10); s_wait("err_a", 1);
    s_result("err_a", 8'd0, 1'b1, 8'h10); s_release("err_a");
    s_issue(2'b11, 8'd1, 8'd2, 8'd251, 8'h11); s_wait("err_mode", 1);
    s_result("err_mode", 8'd0, 1'b1, 8'h11); s_release("err_mode");
    s_issue(2'b01, 8'd0, 8'd0, 8'd1, 8'h12); s_wait("err_q", 1);
    s_result("err_q", 8'd0, 1'b1, 8'h12); s_release("err_q");

    // 4. Backpressure with a pending request
    s_issue(2'b00, 8'd200, 8'd100, 8'd251, 8'h5A);
    s_wait("bp_mul", 8);
    s_mode = 2'b01; s_a = 8'd1; s_b = 8'd2; s_q = 8'd251; s_tag = 8'h77; s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_c", 64'(s_out_c), 64'd171);
      check_eq("bp_hold_valid", 64'(s_out_valid), 64'd1);
      check_eq("bp_hold_ready", 64'(s_in_ready), 64'd0);
    end
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    check_eq("bp_ready_back", 64'(s_in_ready), 64'd1);
    tick();
    s_in_valid = 1'b0;
    s_wait("bp_pending", 1);
    s_result("bp_pending", 8'd3, 1'b0, 8'h77); s_release("bp_pending");

    // 5. Reset in the middle of a MUL
    s_issue(2'b00, 8'd200, 8'd100, 8'd251, 8'h33);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 64'(s_in_ready), 64'd0);
    check_eq("mid_rst_valid", 64'(s_out_valid), 64'd0);
    check_eq("mid_rst_c", 64'(s_out_c), 64'd0);
    check_eq("mid_rst_err", 64'(s_out_err), 64'd0);
    check_eq("mid_rst_tag", 64'(s_out_tag), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_ready", 64'(s_in_ready), 64'd1);
    s_issue(2'b00, 8'd3, 8'd4, 8'd5, 8'h44); s_wait("post_rst", 8);
    s_result("post_rst", 8'd2, 1'b0, 8'h44); s_release("post_rst");

    // 6. Randomized run on the 64-bit instance
    qb = 64'hFFFF_FFFF_FFFF_FFC5;
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom_range(0, 19);
      ra = {$urandom(), $urandom()} % qb;
      rb = {$urandom(), $urandom()} % qb;
      b_mode = 2'($urandom_range(0, 2));
      if (r == 0) b_mode = 2'b11;
      if (r == 1) ra = qb;
      n = 0;
      while (!b_in_ready && n < 50) begin tick(); n++; end
      check_eq("rnd_ready", 64'(b_in_ready), 64'd1);
      b_a = ra; b_b = rb; b_q = qb; b_tag = 8'(i); b_in_valid = 1'b1;
      tag_q.push_back(8'(i));
      exp_r = ref_op(b_mode, ra, rb, qb);
      lat = (b_mode == 2'b00 && !exp_r[64]) ? 16 : 1;
      tick();
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 100) begin tick(); n++; end
      check_eq("rnd_latency", 64'(n), 64'(lat));
      stall = $urandom_range(0, 2);
      repeat (stall) tick();
      exp_tag = tag_q.pop_front();
      check_eq("rnd_c", b_out_c, exp_r[63:0]);
      check_eq("rnd_err", 64'(b_out_err), 64'(exp_r[64]));
      check_eq("rnd_tag", 64'(b_out_tag), 64'(exp_tag));
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
